adc_capture_ctrl: RTL

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

---
 rtl/adc_capture_ctrl_if.sv | 23 ++
 rtl/adc_capture_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl_if.sv
// Register-bus interface of adc_capture_ctrl.
//   user_w_mem_8_wren  host -> ctrl  register write strobe
//   user_w_mem_8_data  host -> ctrl  register write data
//   user_mem_8_addr    host -> ctrl  register address (reads and writes)
//   user_r_mem_8_data  ctrl -> host  registered read data, one cycle latency
//   user_r_mem_8_empty ctrl -> host  always 0: read data is always available
interface adc_capture_ctrl_if;
    logic        user_w_mem_8_wren;
    logic [31:0] user_w_mem_8_data;
    logic [4:0]  user_mem_8_addr;
    logic [31:0] user_r_mem_8_data;
    logic        user_r_mem_8_empty;

    modport master (
        output user_w_mem_8_wren, user_w_mem_8_data, user_mem_8_addr,
        input  user_r_mem_8_data, user_r_mem_8_empty
    );

    modport slave (
        input  user_w_mem_8_wren, user_w_mem_8_data, user_mem_8_addr,
        output user_r_mem_8_data, user_r_mem_8_empty
    );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Two-channel ADC capture controller. The host arms a capture of SAMPLE_COUNT
// aligned samples; accepted samples are written to per-channel FIFOs, samples
// arriving while an enabled FIFO is full are dropped on both channels and flag
// a sticky overflow. After the capture the FIFOs drain, the enabled streams see
// end-of-file, and the controller idles once the host closes them.
//   bus_clk, trn_reset_n        clock, asynchronous active-low reset
//   bus                         register bus (adc_capture_ctrl_if.slave)
//   adc_valid                   one aligned 2-channel sample this cycle
//   chN_fifo_full/empty         capture FIFO flags
//   user_r_chN_read_open        host has stream N open
//   chN_fifo_wren               capture FIFO write enables (combinational)
//   user_r_chN_read_eof         stream end-of-file (registered)
//   capture_busy, overflow      status
// Registers: 0 CTRL (WO: en[1:0], arm, abort, clr_ovf), 1 SAMPLE_COUNT,
//            2 STATUS {mask, overflow, state}, 3 CAPTURED.
module adc_capture_ctrl #(
    parameter int unsigned CNT_W = 24
) (
    input  logic                bus_clk,
    input  logic                trn_reset_n,
    adc_capture_ctrl_if.slave   bus,
    input  logic                adc_valid,
    input  logic                ch1_fifo_full,
    input  logic                ch2_fifo_full,
    input  logic                ch1_fifo_empty,
    input  logic                ch2_fifo_empty,
    input  logic                user_r_ch1_read_open,
    input  logic                user_r_ch2_read_open,
    output logic                ch1_fifo_wren,
    output logic                ch2_fifo_wren,
    output logic                user_r_ch1_read_eof,
    output logic                user_r_ch2_read_eof,
    output logic                capture_busy,
    output logic                overflow
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Reset asserts asynchronously but releases two clocks after trn_reset_n rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) rst_sync_q <= 2'b00;
        else              rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_e           state_q, state_d;
    logic [1:0]       mask_q, mask_d;
    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [CNT_W-1:0] captured_q, captured_d;
    logic             overflow_q, overflow_d;
    logic [1:0]       eof_q, eof_d;
    logic [1:0]       open_q;
    logic [31:0]      rdata_q, rdata_d;

    logic [1:0] fifo_full, fifo_empty, read_open;
    assign fifo_full  = {ch2_fifo_full, ch1_fifo_full};
    assign fifo_empty = {ch2_fifo_empty, ch1_fifo_empty};
    assign read_open  = {user_r_ch2_read_open, user_r_ch1_read_open};

    logic wr_ctrl, wr_count, arm_req, abort_req, clr_ovf;
    assign wr_ctrl   = bus.user_w_mem_8_wren && (bus.user_mem_8_addr == 5'd0);
    assign wr_count  = bus.user_w_mem_8_wren && (bus.user_mem_8_addr == 5'd1);
    assign arm_req   = wr_ctrl && bus.user_w_mem_8_data[2];
    assign abort_req = wr_ctrl && bus.user_w_mem_8_data[3];
    assign clr_ovf   = wr_ctrl && bus.user_w_mem_8_data[4];

    // Write data above the counter width carries nothing.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^bus.user_w_mem_8_data[31:CNT_W];

    logic full_any, accept, drop, last_sample;
    assign full_any    = |(mask_q & fifo_full);
    assign accept      = (state_q == ST_CAPTURE) && adc_valid && !full_any;
    assign drop        = (state_q == ST_CAPTURE) && adc_valid && full_any;
    assign last_sample = accept && ((captured_q + CNT_W'(1)) == sample_count_q);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        captured_d     = captured_q;
        sample_count_d = sample_count_q;
        overflow_d     = overflow_q;
        rdata_d        = 32'd0;

        if (accept && (captured_q != {CNT_W{1'b1}})) captured_d = captured_q + CNT_W'(1);

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop)         overflow_d = 1'b1;
        else if (clr_ovf) overflow_d = 1'b0;

        if (wr_count && (state_q == ST_IDLE))
            sample_count_d = bus.user_w_mem_8_data[CNT_W-1:0];

        unique case (state_q)
            ST_IDLE: begin
                if (arm_req && !abort_req && (bus.user_w_mem_8_data[1:0] != 2'b00)
                    && (sample_count_q != '0)) begin
                    state_d = ST_ARMED;
                    mask_d  = bus.user_w_mem_8_data[1:0];
                end
            end
            ST_ARMED: begin
                // A stream that was open and closed again ends the capture early.
                if (abort_req)                             state_d = ST_IDLE;
                else if (|(mask_q & open_q & ~read_open))  state_d = ST_DRAIN;
                else if ((mask_q & read_open) == mask_q) begin
                    state_d    = ST_CAPTURE;
                    captured_d = '0;
                end
            end
            ST_CAPTURE: begin
                if (abort_req || |(mask_q & ~read_open) || last_sample) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((mask_q & ~fifo_empty) == 2'b00) state_d = ST_DONE;
            end
            ST_DONE: begin
                if ((mask_q & read_open) == 2'b00) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        eof_d = (state_d == ST_DONE) ? mask_q : 2'b00;

        case (bus.user_mem_8_addr)
            5'd1:    rdata_d = 32'(sample_count_q);
            5'd2:    rdata_d = {26'd0, mask_q, overflow_q, state_q};
            5'd3:    rdata_d = 32'(captured_q);
            default: rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            mask_q         <= 2'b00;
            sample_count_q <= '0;
            captured_q     <= '0;
            overflow_q     <= 1'b0;
            eof_q          <= 2'b00;
            open_q         <= 2'b00;
            rdata_q        <= 32'd0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            sample_count_q <= sample_count_d;
            captured_q     <= captured_d;
            overflow_q     <= overflow_d;
            eof_q          <= eof_d;
            open_q         <= read_open;
            rdata_q        <= rdata_d;
        end
    end

    assign ch1_fifo_wren          = accept && mask_q[0];
    assign ch2_fifo_wren          = accept && mask_q[1];
    assign user_r_ch1_read_eof    = eof_q[0];
    assign user_r_ch2_read_eof    = eof_q[1];
    assign capture_busy           = (state_q != ST_IDLE);
    assign overflow               = overflow_q;
    assign bus.user_r_mem_8_data  = rdata_q;
    assign bus.user_r_mem_8_empty = 1'b0;
endmodule
